secuenciador_luces: RTL and testbench

//  Downstream consumer of the 1 Hz square wave and 200 ms blink pulse made by the
//  1 Hz counter/blink stage; drives an N-LED bar. A pushbutton cycles through five

---
 rtl/secuenciador_luces_pkg.sv | 28 ++
 rtl/secuenciador_luces_antirrebote.sv | 50 +++++
 rtl/secuenciador_luces.sv | 129 ++++++++++++
 tb/tb_secuenciador_luces.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_luces_pkg.sv
// Shared definitions for the LED bar sequencer:
// mode codes, default debounce length and the mode order.
package secuenciador_luces_pkg;

  typedef enum logic [2:0] {
    MODO_APAGADO      = 3'd0,
    MODO_INTERMITENTE = 3'd1,
    MODO_IZQUIERDA    = 3'd2,
    MODO_DERECHA      = 3'd3,
    MODO_VAIVEN       = 3'd4
  } modo_t;

  localparam int DEBOUNCE_DEF = 1_000_000;

  // Unused codes fall back to APAGADO.
  function automatic modo_t modo_sig(
    input modo_t m
  );
    case (m)
      MODO_APAGADO:      modo_sig = MODO_INTERMITENTE;
      MODO_INTERMITENTE: modo_sig = MODO_IZQUIERDA;
      MODO_IZQUIERDA:    modo_sig = MODO_DERECHA;
      MODO_DERECHA:      modo_sig = MODO_VAIVEN;
      default:           modo_sig = MODO_APAGADO;
    endcase
  endfunction

endpackage

// File: rtl/secuenciador_luces_antirrebote.sv
// Pushbutton conditioning: synchronizer, debounce counter
// and a one-cycle strobe on each accepted press.
module antirrebote
  import secuenciador_luces_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic Reloj,
  input  logic Reset_n,
  input  logic entrada,
  output logic pulsacion
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   estable;
  logic                   estable_d;
  logic                   muestra;

  assign muestra   = sync[SYNC_STAGES-1];
  assign pulsacion = estable & ~estable_d;

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      sync      <= '0;
      cnt       <= '0;
      estable   <= 1'b0;
      estable_d <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], entrada};
      estable_d <= estable;
      // Any glitch back to the stable level restarts the count.
      if (muestra == estable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        estable <= muestra;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/secuenciador_luces.sv
// LED bar sequencer: five light modes stepped by the 1 Hz
// square wave, selected with a debounced pushbutton.
module secuenciador_luces
  import secuenciador_luces_pkg::*;
#(
  parameter int N_LEDS          = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              Reloj,
  input  logic              Reset_n,
  input  logic              Senal_1HZ,
  input  logic              Senal_Blink,
  input  logic              Boton,
  output logic [N_LEDS-1:0] LEDS,
  output logic [2:0]        Modo
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] P_MAX = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] P_PEN = PW'(N_LEDS - 2);
  localparam logic [N_LEDS-1:0] UNO = N_LEDS'(1);

  logic [SYNC_STAGES-1:0] hz_s;
  logic [SYNC_STAGES-1:0] bl_s;
  logic                   hz_d;
  logic                   paso;
  logic                   blink;
  logic                   pulsacion;
  modo_t                  modo;
  modo_t                  modo_n;
  logic [PW-1:0]          pos;
  logic                   dir_up;
  logic [N_LEDS-1:0]      leds_d;

  antirrebote #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .Reloj    (Reloj),
    .Reset_n  (Reset_n),
    .entrada  (Boton),
    .pulsacion(pulsacion)
  );

  // Both edges of the square wave step: two steps per second.
  assign paso   = hz_s[SYNC_STAGES-1] ^ hz_d;
  assign blink  = bl_s[SYNC_STAGES-1];
  assign modo_n = modo_sig(modo);
  assign Modo   = modo;

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      hz_s <= '0;
      bl_s <= '0;
      hz_d <= 1'b0;
    end else begin
      hz_s <= {hz_s[SYNC_STAGES-2:0], Senal_1HZ};
      bl_s <= {bl_s[SYNC_STAGES-2:0], Senal_Blink};
      hz_d <= hz_s[SYNC_STAGES-1];
    end
  end

  always_comb begin
    leds_d = '0;
    case (modo)
      MODO_INTERMITENTE: leds_d = {N_LEDS{blink}};
      MODO_IZQUIERDA,
      MODO_DERECHA,
      MODO_VAIVEN:       leds_d = UNO << pos;
      default:           leds_d = '0;
    endcase
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      modo   <= MODO_APAGADO;
      pos    <= '0;
      dir_up <= 1'b1;
      LEDS   <= '0;
    end else begin
      LEDS <= leds_d;
      // A mode change swallows a coincident step.
      if (pulsacion) begin
        modo   <= modo_n;
        pos    <= (modo_n == MODO_DERECHA) ? P_MAX : '0;
        dir_up <= 1'b1;
      end else begin
        case (modo)
          MODO_APAGADO,
          MODO_INTERMITENTE: ;
          MODO_IZQUIERDA: begin
            if (paso)
              pos <= (pos == P_MAX) ? '0 : pos + PW'(1);
          end
          MODO_DERECHA: begin
            if (paso)
              pos <= (pos == '0) ? P_MAX : pos - PW'(1);
          end
          MODO_VAIVEN: begin
            if (paso) begin
              if (dir_up) begin
                if (pos == P_MAX) begin
                  pos    <= P_PEN;
                  dir_up <= 1'b0;
                end else begin
                  pos <= pos + PW'(1);
                end
              end else begin
                if (pos == '0) begin
                  pos    <= PW'(1);
                  dir_up <= 1'b1;
                end else begin
                  pos <= pos - PW'(1);
                end
              end
            end
          end
          default: begin
            modo   <= MODO_APAGADO;
            pos    <= '0;
            dir_up <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_luces.sv
// Bench for secuenciador_luces: directed scenarios plus random
// actions checked against a position/mode reference model.
module tb_secuenciador_luces;

  localparam int N = 8;

  logic         Reloj = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Senal_1HZ = 1'b0;
  logic         Senal_Blink = 1'b0;
  logic         Boton = 1'b0;
  logic [N-1:0] LEDS;
  logic [2:0]   Modo;

  int checks = 0;
  int errors = 0;

  int m_modo = 0;
  int m_pos  = 0;
  int m_k    = 0;
  bit m_blink = 1'b0;

  secuenciador_luces #(
    .N_LEDS         (N),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .Reloj      (Reloj),
    .Reset_n    (Reset_n),
    .Senal_1HZ  (Senal_1HZ),
    .Senal_Blink(Senal_Blink),
    .Boton      (Boton),
    .LEDS       (LEDS),
    .Modo       (Modo)
  );

  always #10 Reloj = ~Reloj;

  task automatic tick(input int n);
    repeat (n) @(posedge Reloj);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_leds();
    logic [N-1:0] v;
    v = '0;
    if (m_modo == 1) v = m_blink ? '1 : '0;
    else if (m_modo >= 2) v = N'(1) << m_pos;
    return v;
  endfunction

  task automatic m_reset();
    m_modo = 0; m_pos = 0; m_k = 0;
  endtask

  task automatic m_press();
    m_modo = (m_modo + 1) % 5;
    m_pos  = (m_modo == 3) ? N - 1 : 0;
    m_k    = 0;
  endtask

  // Bounce mode walks a 2N-2 long triangle: 0..N-1..1.
  task automatic m_step();
    case (m_modo)
      2: m_pos = (m_pos + 1) % N;
      3: m_pos = (m_pos + N - 1) % N;
      4: begin
        m_k   = (m_k + 1) % (2 * N - 2);
        m_pos = (m_k < N) ? m_k : 2 * N - 2 - m_k;
      end
      default: ;
    endcase
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_leds"}, 32'(LEDS), 32'(exp_leds()));
    chk({tag, "_modo"}, 32'(Modo), 32'(m_modo));
  endtask

  task automatic press(input int glitches);
    repeat (glitches) begin
      Boton = 1'b1; tick($urandom_range(1, 3));
      Boton = 1'b0; tick($urandom_range(1, 3));
    end
    Boton = 1'b1; tick(12);
    repeat (glitches) begin
      Boton = 1'b0; tick($urandom_range(1, 3));
      Boton = 1'b1; tick($urandom_range(1, 3));
    end
    Boton = 1'b0; tick(12);
    m_press();
  endtask

  task automatic hz();
    Senal_1HZ = ~Senal_1HZ;
    tick(6);
    m_step();
  endtask

  initial begin
    // Reset with inputs toggling.
    repeat (10) begin
      Senal_1HZ   = 1'($urandom);
      Senal_Blink = 1'($urandom);
      Boton       = 1'($urandom);
      tick(1);
    end
    chk_state("rst");
    Senal_1HZ = 0; Senal_Blink = 0; Boton = 0;
    tick(1);
    Reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk_state("idle");
    end

    // Bouncy press: exactly one advance.
    for (int i = 0; i < 4; i++) begin
      Boton = ~Boton; tick(2);
    end
    chk("bounce_pre", 32'(Modo), 32'd0);
    Boton = 1'b1; tick(20);
    Boton = 1'b0; tick(12);
    m_press();
    chk_state("bounce");

    // Hazard flash, exact blink latency.
    Senal_Blink = 1'b1; m_blink = 1'b1;
    tick(2); chk("haz_on_early", 32'(LEDS), 32'h00);
    tick(1); chk("haz_on", 32'(LEDS), 32'hFF);
    Senal_Blink = 1'b0; m_blink = 1'b0;
    tick(2); chk("haz_off_early", 32'(LEDS), 32'hFF);
    tick(1); chk("haz_off", 32'(LEDS), 32'h00);

    press(0);
    chk_state("izq_entry");
    // First step: LEDS moves on the fourth edge.
    Senal_1HZ = ~Senal_1HZ;
    tick(3); chk("paso_early", 32'(LEDS), 32'h01);
    tick(1); chk("paso_lat", 32'(LEDS), 32'h02);
    tick(2); m_step();
    for (int i = 1; i < 9; i++) begin
      hz(); chk_state("izq");
    end

    press(0);
    chk_state("der_entry");
    for (int i = 0; i < 8; i++) begin
      hz(); chk_state("der");
    end

    press(0);
    chk_state("vai_entry");
    for (int i = 0; i < 16; i++) begin
      hz(); chk_state("vai");
    end

    // Round to IZQUIERDA at pos 3, then press and step together.
    press(0); press(0); press(0);
    chk_state("cyc_izq");
    repeat (3) hz();
    chk_state("col_pre");
    Boton = 1'b1;
    tick(4);
    Senal_1HZ = ~Senal_1HZ;
    tick(8);
    Boton = 1'b0; tick(12);
    m_press();
    chk_state("col");
    chk("col_leds", 32'(LEDS), 32'h80);

    // Asynchronous reset mid-bounce.
    press(0);
    repeat (5) hz();
    chk_state("vai_mid");
    Reset_n = 1'b0;
    #2;
    m_reset();
    chk("arst_leds", 32'(LEDS), 32'h00);
    chk("arst_modo", 32'(Modo), 32'd0);
    tick(2);
    Reset_n = 1'b1;
    tick(5);
    chk_state("arst_rel");

    // Random actions.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: press($urandom_range(0, 3));
        1, 2: hz();
        default: begin
          Senal_Blink = ~Senal_Blink;
          m_blink = Senal_Blink;
          tick(6);
        end
      endcase
      chk_state("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
